dma_rd_engine: RTL and testbench

//  Read master of the DMA data path. Accepts one read descriptor (source byte address, byte length).

---
 rtl/dma_pkg.sv | 20 ++
 rtl/ofs_plat_axi_mem_if.sv | 64 ++++++
 rtl/dma_rd_data_fifo.sv | 46 ++++
 rtl/dma_rd_engine.sv | 174 +++++++++++++++++
 tb/tb_dma_rd_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: page size, AXI encodings, read-descriptor record and read FSM states.
package dma_pkg;

  localparam int unsigned DMA_4KB_BYTES  = 4096;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [63:0] addr;
    logic [23:0] length;
  } t_dma_rd_desc;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN,
    RD_DONE
  } e_dma_rd_state;

endpackage

// File: rtl/ofs_plat_axi_mem_if.sv
// AXI-MM memory interface; to_sink is the master side, to_source the slave side.
interface ofs_plat_axi_mem_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512
);
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arid;
  logic [3:0]              arcache;
  logic [2:0]              arprot;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport to_sink (
    output arvalid, araddr, arlen, arsize, arburst, arid, arcache, arprot,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport to_source (
    input  arvalid, araddr, arlen, arsize, arburst, arid, arcache, arprot,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/dma_rd_data_fifo.sv
// Synchronous first-word-fall-through FIFO for returned read beats.
module dma_rd_data_fifo #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Head entry is read combinationally so the oldest beat is presented without a pop.
  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/dma_rd_engine.sv
// DMA read master: splits one descriptor into 4 KB-safe INCR bursts and streams the returned beats.
module dma_rd_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned LEN_WIDTH       = 24,
  parameter int unsigned MAX_BURST_BEATS = 64,
  parameter int unsigned FIFO_DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_src_addr,
  input  logic [LEN_WIDTH-1:0]  desc_length,
  ofs_plat_axi_mem_if.to_sink   src_mem,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned OFFS       = $clog2(BYTES);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PAGE_BEATS = DMA_4KB_BYTES / BYTES;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  e_dma_rd_state         state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  total;
  logic [LEN_WIDTH-1:0]  delivered;
  logic [CW-1:0]         credits;

  logic [LEN_WIDTH-1:0]  desc_beats;
  logic [12:0]           beats_4k;
  logic [LEN_WIDTH-1:0]  burst;
  logic                  credit_ok;
  logic                  ar_valid;
  logic                  ar_hs;
  logic                  desc_acc;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  unused_ifc;

  assign desc_beats = LEN_WIDTH'(desc_length >> OFFS);
  assign beats_4k   = 13'(PAGE_BEATS) - 13'(cur_addr[11:OFFS]);

  always_comb begin
    burst = remaining;
    if (burst > LEN_WIDTH'(MAX_BURST_BEATS)) burst = LEN_WIDTH'(MAX_BURST_BEATS);
    if (burst > LEN_WIDTH'(beats_4k))        burst = LEN_WIDTH'(beats_4k);
  end

  assign credit_ok = (LEN_WIDTH'(credits) >= burst);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RD_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    desc_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ar_valid   = 1'b0;
    unique case (state)
      RD_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) state_nxt = (desc_beats == '0) ? RD_DONE : RD_ISSUE;
      end
      RD_ISSUE: begin
        busy     = 1'b1;
        ar_valid = credit_ok;
        if (credit_ok && src_mem.arready && (burst == remaining)) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        busy = 1'b1;
        if (pop && rd_last) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        done      = 1'b1;
        state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign desc_acc = desc_valid && desc_ready;
  assign ar_hs    = ar_valid && src_mem.arready;
  assign push     = src_mem.rvalid && src_mem.rready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      total     <= '0;
      delivered <= '0;
      error     <= 1'b0;
    end else if (desc_acc) begin
      cur_addr  <= desc_src_addr & ~ADDR_WIDTH'(BYTES - 1);
      remaining <= desc_beats;
      total     <= desc_beats;
      delivered <= '0;
      error     <= 1'b0;
    end else begin
      if (ar_hs) begin
        cur_addr  <= cur_addr + (ADDR_WIDTH'(burst) << OFFS);
        remaining <= remaining - burst;
      end
      if (pop) delivered <= delivered + LEN_WIDTH'(1);
      if (push && (src_mem.rresp != AXI_RESP_OKAY)) error <= 1'b1;
    end
  end

  // Space is reserved at AR time and returned per popped beat; both may happen in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credits <= DEPTH_C;
    else          credits <= credits + CW'(pop) - (ar_hs ? CW'(burst) : CW'(0));
  end

  dma_rd_data_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (src_mem.rdata),
    .pop       (pop),
    .pop_data  (rd_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_last  = rd_valid && (delivered == total - LEN_WIDTH'(1));

  assign src_mem.arvalid = ar_valid;
  assign src_mem.araddr  = cur_addr;
  assign src_mem.arlen   = 8'(burst - LEN_WIDTH'(1));
  assign src_mem.arsize  = 3'(OFFS);
  assign src_mem.arburst = AXI_BURST_INCR;
  assign src_mem.arid    = '0;
  assign src_mem.arcache = '0;
  assign src_mem.arprot  = '0;
  assign src_mem.rready  = 1'b1;

  assign src_mem.awvalid = 1'b0;
  assign src_mem.awaddr  = '0;
  assign src_mem.awlen   = '0;
  assign src_mem.awsize  = '0;
  assign src_mem.awburst = '0;
  assign src_mem.wvalid  = 1'b0;
  assign src_mem.wdata   = '0;
  assign src_mem.wstrb   = '0;
  assign src_mem.wlast   = 1'b0;
  assign src_mem.bready  = 1'b1;

  // Framing comes from the beat counter, so r.last and the write channel are not consulted.
  assign unused_ifc = ^{src_mem.rlast, src_mem.awready, src_mem.wready, src_mem.bvalid, src_mem.bresp};

  assert property (@(posedge clk) disable iff (!reset_n) fifo_count <= DEPTH_C - credits);

endmodule

// File: tb/tb_dma_rd_engine.sv
// Randomized bench for dma_rd_engine against a descriptor-level burst/beat model.
module tb_dma_rd_engine;

  localparam int unsigned BYTES = 64;
  localparam int unsigned DEPTH = 64;

  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [511:0] data; logic last; } beat_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         desc_valid;
  logic         desc_ready;
  logic [63:0]  desc_src_addr;
  logic [23:0]  desc_length;
  logic         rd_valid;
  logic         rd_ready;
  logic [511:0] rd_data;
  logic         rd_last;
  logic         busy;
  logic         done;
  logic         error;

  ofs_plat_axi_mem_if #(.ADDR_WIDTH(64), .DATA_WIDTH(512)) mem_if ();

  dma_rd_engine #(
    .ADDR_WIDTH      (64),
    .DATA_WIDTH      (512),
    .LEN_WIDTH       (24),
    .MAX_BURST_BEATS (64),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_src_addr (desc_src_addr),
    .desc_length   (desc_length),
    .src_mem       (mem_if),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ar_t         exp_ar[$];
  beat_t       exp_beat[$];
  logic [63:0] r_pend[$];
  logic [31:0] salt = '0;
  int          err_beat = -1;
  int          r_idx = 0;
  int          ready_mode = 1;
  int unsigned ar_seen = 0;
  int unsigned ar_beats = 0;
  int unsigned n_popped = 0;
  bit          exp_err = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] beat_data(input logic [63:0] a);
    return {4{a ^ {32'h0, salt}, ~a}};
  endfunction

  // Reference: walk the byte range, cutting at 64 beats and at every 4 KB page edge.
  task automatic build_model(input logic [63:0] a, input int unsigned nbeats);
    logic [63:0] p;
    int unsigned left, room, b;
    p = a;
    left = nbeats;
    exp_ar.delete();
    exp_beat.delete();
    while (left > 0) begin
      room = (4096 - int'(p[11:0])) / BYTES;
      b = left;
      if (b > 64) b = 64;
      if (b > room) b = room;
      exp_ar.push_back('{p, 8'(b - 1)});
      for (int unsigned i = 0; i < b; i++)
        exp_beat.push_back('{beat_data(p + 64'(BYTES * i)), (left == b) && (i == b - 1)});
      p = p + 64'(BYTES * b);
      left = left - b;
    end
  endtask

  // AXI slave: accepts AR with random stalls, returns beats in order with random gaps.
  initial begin
    bit   r_fire;
    ar_t  ea;
    bit   ar_pend = 1'b0;
    ar_t  ar_prev;
    mem_if.arready = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    mem_if.rresp   = '0;
    mem_if.rlast   = 1'b0;
    mem_if.awready = 1'b0;
    mem_if.wready  = 1'b0;
    mem_if.bvalid  = 1'b0;
    mem_if.bresp   = '0;
    forever begin
      @(negedge clk);
      r_fire = 1'b0;
      if (!reset_n) begin
        r_pend.delete();
        ar_pend = 1'b0;
      end else begin
        r_fire = mem_if.rvalid && mem_if.rready;
        if (ar_pend) begin
          chk("ar_hold_valid", mem_if.arvalid, 1'b1);
          chk("ar_hold_addr", mem_if.araddr, ar_prev.addr);
          chk("ar_hold_len", mem_if.arlen, ar_prev.len);
        end
        ar_pend = mem_if.arvalid && !mem_if.arready;
        ar_prev = '{mem_if.araddr, mem_if.arlen};
        if (mem_if.arvalid && mem_if.arready) begin
          ar_seen++;
          if (exp_ar.size() == 0) chk("ar_extra", 1'b1, 1'b0);
          else begin
            ea = exp_ar.pop_front();
            chk("ar_addr", mem_if.araddr, ea.addr);
            chk("ar_len", mem_if.arlen, ea.len);
          end
          chk("ar_size", mem_if.arsize, 3'd6);
          chk("ar_burst", mem_if.arburst, 2'b01);
          chk("ar_id", mem_if.arid, 4'd0);
          ar_beats += int'(mem_if.arlen) + 1;
          chk("credit_bound", (ar_beats - n_popped) <= DEPTH, 1'b1);
          for (int unsigned i = 0; i <= int'(mem_if.arlen); i++)
            r_pend.push_back(mem_if.araddr + 64'(BYTES * i));
        end
      end
      @(posedge clk);
      #1;
      if (r_fire && r_pend.size() > 0) begin
        void'(r_pend.pop_front());
        r_idx++;
      end
      if (!reset_n) begin
        mem_if.arready = 1'b0;
        mem_if.rvalid  = 1'b0;
      end else begin
        mem_if.arready = ($urandom_range(0, 3) != 0);
        if (!mem_if.rvalid || r_fire) begin
          if (r_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = beat_data(r_pend[0]);
            mem_if.rresp  = (r_idx == err_beat) ? 2'b10 : 2'b00;
          end else begin
            mem_if.rvalid = 1'b0;
          end
        end
      end
    end
  end

  // Stream consumer and beat checker.
  initial begin
    beat_t eb;
    bit    hold = 1'b0;
    logic [511:0] hold_data;
    rd_ready = 1'b0;
    fork
      forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
          0:       rd_ready = 1'b0;
          1:       rd_ready = 1'b1;
          default: rd_ready = ($urandom_range(0, 2) != 0);
        endcase
      end
      forever begin
        @(negedge clk);
        if (!reset_n) hold = 1'b0;
        else begin
          if (hold) begin
            chk("rd_hold_valid", rd_valid, 1'b1);
            chk("rd_hold_data", rd_data, hold_data);
          end
          hold = rd_valid && !rd_ready;
          hold_data = rd_data;
          if (rd_valid && rd_ready) begin
            n_popped++;
            if (exp_beat.size() == 0) chk("beat_extra", 1'b1, 1'b0);
            else begin
              eb = exp_beat.pop_front();
              chk("rd_data", rd_data, eb.data);
              chk("rd_last", rd_last, eb.last);
            end
          end
        end
      end
    join
  end

  task automatic start_desc(input logic [63:0] addr_raw, input int unsigned nb,
                            input int unsigned len_junk, input int eb);
    salt = $urandom;
    build_model(addr_raw & ~64'h3F, nb);
    err_beat = eb;
    r_idx    = 0;
    ar_seen  = 0;
    ar_beats = 0;
    n_popped = 0;
    exp_err  = (eb >= 0) && (eb < int'(nb));
    chk("desc_ready_idle", desc_ready, 1'b1);
    desc_src_addr = addr_raw;
    desc_length   = 24'(nb * BYTES + len_junk);
    desc_valid    = 1'b1;
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    chk("err_clear_on_accept", error, 1'b0);
    if (nb == 0) chk("len0_done", done, 1'b1);
    else         chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      chk("done_timeout", 1'b0, 1'b1);
      return;
    end
    chk("beats_left", 32'(exp_beat.size()), 32'd0);
    chk("ar_left", 32'(exp_ar.size()), 32'd0);
    chk("busy_in_done", busy, 1'b0);
    chk("desc_ready_in_done", desc_ready, 1'b0);
    chk("error_at_done", error, exp_err);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("desc_ready_back", desc_ready, 1'b1);
    chk("error_sticky", error, exp_err);
  endtask

  task automatic run_desc(input logic [63:0] addr_raw, input int unsigned nb,
                          input int unsigned len_junk, input int eb, input int mode);
    ready_mode = mode;
    start_desc(addr_raw, nb, len_junk, eb);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 1'b1);
    chk({tag, "_arvalid"}, mem_if.arvalid, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_last"}, rd_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int unsigned nb;
    int          eb;
    reset_n       = 1'b0;
    desc_valid    = 1'b0;
    desc_src_addr = '0;
    desc_length   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_awvalid", mem_if.awvalid, 1'b0);
    chk("reset_wvalid", mem_if.wvalid, 1'b0);
    chk("reset_bready", mem_if.bready, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rready_const", mem_if.rready, 1'b1);

    run_desc(64'h1000, 4, 0, -1, 1);
    run_desc(64'h0FC0, 8, 0, -1, 2);
    run_desc(64'h0, 256, 0, -1, 2);

    ready_mode = 0;
    start_desc(64'h0, 256, 0, -1);
    repeat (150) @(posedge clk);
    #1;
    chk("stall_ar_count", 32'(ar_seen), 32'd1);
    chk("stall_rd_valid", rd_valid, 1'b1);
    ready_mode = 2;
    wait_done();

    run_desc(64'h2000, 4, 0, 1, 2);
    run_desc(64'h3000, 0, 0, -1, 1);
    run_desc(64'h5F80, 3, 17, -1, 2);
    run_desc(64'h7000, 0, 63, -1, 1);

    for (int t = 0; t < 10; t++) begin
      a = {$urandom, $urandom};
      a[63] = 1'b0;
      nb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 200);
      eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb)) : -1;
      run_desc(a, nb, $urandom_range(0, 63), eb, $urandom_range(1, 2));
    end

    ready_mode = 2;
    start_desc(64'h0, 256, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_ar.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_desc(64'h1000, 4, 0, -1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
